// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between two byte FIFOs, A-first with a burst limit.
// Define UART_TX_ARB_TIMEOUT_EN to add the tx_done watchdog and timeout_err port.
module uart_tx_arbiter #(
   parameter int DATA_BITS = 8,
   parameter int BURST_LEN = 16,
   parameter int TIMEOUT   = 200000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] data_A,
   input  logic [DATA_BITS-1:0] data_B,
   input  logic                 not_emptyA,
   input  logic                 not_emptyB,
   input  logic                 tx_done,
   output logic                 readA,
   output logic                 readB,
   output logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_start,
   output logic                 src,
`ifdef UART_TX_ARB_TIMEOUT_EN
   output logic                 timeout_err,
`endif
   output logic                 busy
);

   if (BURST_LEN < 1 || BURST_LEN > 255 || TIMEOUT < 1) begin : g_bad_param
      $error("uart_tx_arbiter: BURST_LEN must be 1..255, TIMEOUT >= 1");
   end

   typedef enum logic [2:0] {IDLE, POP, LOAD, SEND, WAIT} state_t;

   localparam logic [7:0] BL = 8'(BURST_LEN);

   state_t               state_q, state_d;
   logic                 src_q, src_d;
   logic                 last_q, last_d;
   logic [7:0]           burst_q, burst_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 readA_q, readB_q, start_q, busy_q;
   logic                 pick;

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
   logic [TW-1:0] tmr_q, tmr_d;
   logic          err_q, err_d;
`endif

   // Stay on the last source unless its burst is used up and the other one waits.
   always_comb begin
      pick = last_q;
      if (not_emptyA && !not_emptyB)
         pick = 1'b0;
      else if (!not_emptyA && not_emptyB)
         pick = 1'b1;
      else if (burst_q == BL)
         pick = ~last_q;
   end

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      last_d  = last_q;
      burst_d = burst_q;
      data_d  = data_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
      tmr_d   = tmr_q;
      err_d   = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (not_emptyA || not_emptyB) begin
               src_d   = pick;
               last_d  = pick;
               state_d = POP;
               if (pick != last_q)
                  burst_d = 8'd1;
               else if (burst_q != BL)
                  burst_d = burst_q + 8'd1;
            end
         end
         POP:  state_d = LOAD;
         LOAD: begin
            data_d  = src_q ? data_B : data_A;
            state_d = SEND;
         end
         SEND: begin
            state_d = WAIT;
`ifdef UART_TX_ARB_TIMEOUT_EN
            tmr_d   = TW'(1);
`endif
         end
         WAIT: begin
            if (tx_done)
               state_d = IDLE;
`ifdef UART_TX_ARB_TIMEOUT_EN
            else if (tmr_q >= TMAX) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else
               tmr_d = tmr_q + TW'(1);
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         src_q   <= 1'b0;
         last_q  <= 1'b0;
         burst_q <= 8'd0;
         data_q  <= '0;
         readA_q <= 1'b0;
         readB_q <= 1'b0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         last_q  <= last_d;
         burst_q <= burst_d;
         data_q  <= data_d;
         readA_q <= (state_d == POP) && !src_d;
         readB_q <= (state_d == POP) && src_d;
         start_q <= (state_d == SEND);
         busy_q  <= (state_d != IDLE);
      end
   end

`ifdef UART_TX_ARB_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmr_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmr_q <= tmr_d;
         err_q <= err_d;
      end
   end

   assign timeout_err = err_q;
`endif

   assign readA    = readA_q;
   assign readB    = readB_q;
   assign tx_data  = data_q;
   assign tx_start = start_q;
   assign src      = src_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: FIFO models, tx_done responder, grant model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
   localparam int BL = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data_A = '0, data_B = '0;
   logic       not_emptyA = 1'b0, not_emptyB = 1'b0, tx_done = 1'b0;
   logic       readA, readB, tx_start, src, busy;
   logic [7:0] tx_data;
`ifdef UART_TX_ARB_TIMEOUT_EN
   logic       timeout_err;
`endif

   uart_tx_arbiter #(.DATA_BITS(8), .BURST_LEN(BL), .TIMEOUT(50)) dut (
      .clk(clk), .rst(rst), .data_A(data_A), .data_B(data_B),
      .not_emptyA(not_emptyA), .not_emptyB(not_emptyB), .tx_done(tx_done),
      .readA(readA), .readB(readB), .tx_data(tx_data), .tx_start(tx_start),
      .src(src),
`ifdef UART_TX_ARB_TIMEOUT_EN
      .timeout_err(timeout_err),
`endif
      .busy(busy));

   always #5 clk = ~clk;

   typedef struct packed { logic s; logic [7:0] d; } exp_t;

   exp_t       sb[$];
   logic [7:0] qA[$], qB[$], mA[$], mB[$];
   int         m_run = 0;
   logic       m_last = 1'b0;
   int         n_chk = 0, n_fail = 0;
   int         popsA = 0, popsB = 0, starts = 0;
   int         dly = 5;
   bit         rnd_dly = 0, early = 0, withhold = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic void refresh();
      not_emptyA = (qA.size() != 0);
      not_emptyB = (qB.size() != 0);
   endfunction

   function automatic void push_byte(input logic s, input logic [7:0] b);
      if (s) begin qB.push_back(b); mB.push_back(b); end
      else   begin qA.push_back(b); mA.push_back(b); end
   endfunction

   // Grant order from the arbitration rule applied to the queued bytes.
   function automatic void run_model();
      exp_t e;
      logic s;
      while (mA.size() != 0 || mB.size() != 0) begin
         if (mA.size() != 0 && mB.size() != 0)
            s = (m_run == BL) ? !m_last : m_last;
         else
            s = (mB.size() != 0);
         if (s == m_last) m_run = (m_run < BL) ? m_run + 1 : BL;
         else             m_run = 1;
         m_last = s;
         e.s = s;
         e.d = s ? mB.pop_front() : mA.pop_front();
         sb.push_back(e);
      end
   endfunction

   task automatic push_phase(input int na, input int nb);
      for (int i = 0; i < na; i++) push_byte(1'b0, 8'($urandom));
      for (int i = 0; i < nb; i++) push_byte(1'b1, 8'($urandom));
      run_model();
      refresh();
   endtask

   task automatic drain(input string nm);
      int c = 0;
      while ((sb.size() != 0 || busy || qA.size() != 0 || qB.size() != 0) && c < 5000) begin
         @(negedge clk);
         c++;
      end
      chk({nm, "_drain_timeout"}, 32'(c >= 5000), 0);
      @(negedge clk);
   endtask

   // FIFO models: pop on the strobe, data valid from then on.
   always @(negedge clk) begin
      if (!rst && (readA || readB)) begin
         chk("strobe_onehot", 32'(readA & readB), 0);
         if (readA) begin
            popsA++;
            chk("popA_avail", 32'(qA.size() == 0), 0);
            if (qA.size() != 0) data_A = qA.pop_front();
         end
         if (readB) begin
            popsB++;
            chk("popB_avail", 32'(qB.size() == 0), 0);
            if (qB.size() != 0) data_B = qB.pop_front();
         end
         refresh();
      end
   end

   // Monitor: each tx_start is matched against the oldest expected byte.
   always @(negedge clk) begin
      if (!rst && tx_start) begin
         exp_t e;
         starts++;
         chk("busy_at_start", 32'(busy), 1);
         chk("sb_pending", 32'(sb.size() == 0), 0);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("src", 32'(src), 32'(e.s));
            chk("tx_data", 32'(tx_data), 32'(e.d));
         end
      end
   end

   // UART core stand-in.
   initial begin
      int d;
      forever begin
         @(negedge clk);
         if (!rst && tx_start && !withhold) begin
            d = rnd_dly ? int'($urandom_range(1, 6)) : dly;
            if (early) begin
               tx_done = 1'b1;
               @(negedge clk);
               tx_done = 1'b0;
               d--;
            end
            repeat (d) @(negedge clk);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
         end
      end
   end

   initial begin
      int ra, rs, ri, c, pa, pb;
      repeat (3) @(negedge clk);
      chk("rst_readA", 32'(readA), 0);
      chk("rst_readB", 32'(readB), 0);
      chk("rst_tx_start", 32'(tx_start), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_src", 32'(src), 0);
      chk("rst_tx_data", 32'(tx_data), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Latency of a single byte from A.
      push_byte(1'b0, 8'h41);
      run_model();
      refresh();
      ra = -1; rs = -1; ri = -1;
      for (int cyc = 1; cyc <= 30 && ri < 0; cyc++) begin
         @(posedge clk);
         #1;
         if (readA && ra < 0) ra = cyc;
         if (tx_start && rs < 0) begin
            rs = cyc;
            chk("lat_data", 32'(tx_data), 32'h41);
         end
         if (rs > 0 && !busy && ri < 0) ri = cyc;
      end
      chk("lat_readA", 32'(ra), 1);
      chk("lat_tx_start", 32'(rs), 3);
      chk("lat_idle", 32'(ri), 9);
      drain("lat");

      // tx_done in IDLE is ignored.
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("idle_done_busy", 32'(busy), 0);
         chk("idle_done_read", 32'(readA | readB), 0);
      end

      // tx_done during SEND is ignored; the byte waits for the real one.
      early = 1; dly = 6;
      push_byte(1'b1, 8'h9C);
      run_model();
      refresh();
      c = 0;
      while (!tx_start && c < 50) begin @(negedge clk); c++; end
      chk("send_start_seen", 32'(tx_start), 1);
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("send_done_ignored", 32'(busy), 1);
      end
      drain("send_done");
      early = 0; dly = 5;

      // Both sources busy: bursts of BL alternate.
      pa = popsA; pb = popsB;
      push_phase(10, 10);
      drain("burst");
      chk("burst_popsA", 32'(popsA - pa), 10);
      chk("burst_popsB", 32'(popsB - pb), 10);

      // B alone must not stall at its burst limit.
      pb = popsB;
      push_phase(0, 20);
      drain("b_only");
      chk("b_only_pops", 32'(popsB - pb), 20);

      // Reset while waiting for tx_done.
      withhold = 1;
      push_byte(1'b1, 8'h5A);
      run_model();
      refresh();
      c = 0;
      while (!tx_start && c < 50) begin @(negedge clk); c++; end
      repeat (2) @(negedge clk);
      chk("src_before_rst", 32'(src), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_readA", 32'(readA), 0);
      chk("mid_rst_readB", 32'(readB), 0);
      chk("mid_rst_tx_start", 32'(tx_start), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_src", 32'(src), 0);
      chk("mid_rst_tx_data", 32'(tx_data), 0);
      @(negedge clk);
      rst = 1'b0;
      withhold = 0;
      m_last = 1'b0;
      m_run = 0;
      push_byte(1'b0, 8'hC3);
      run_model();
      refresh();
      drain("after_rst");

`ifdef UART_TX_ARB_TIMEOUT_EN
      withhold = 1;
      push_byte(1'b0, 8'h77);
      run_model();
      refresh();
      c = 0;
      while (!tx_start && c < 50) begin @(posedge clk); #1; c++; end
      c = 0;
      while (!timeout_err && c < 200) begin @(posedge clk); #1; c++; end
      chk("timeout_cycles", 32'(c), 50);
      chk("timeout_idle", 32'(busy), 0);
      withhold = 0;
      @(negedge clk);
      push_phase(1, 1);
      drain("after_timeout");
`endif

      // Random traffic with random tx_done delays.
      rnd_dly = 1;
      for (int p = 0; p < 10; p++) begin
         push_phase(int'($urandom_range(0, 10)), int'($urandom_range(0, 10)));
         drain("random");
      end

      chk("pops_vs_starts", 32'(popsA + popsB), 32'(starts));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
